// File: rtl/mc_control_fsm.sv
// Multicycle RV32I/M control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// decodes ALU operations, handshakes with memory and records sticky traps.
module mc_control_fsm #(
    parameter int ENABLE_M     = 1,
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       branch_res,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic       trap,
    output logic [1:0] trap_cause
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3,  ALU_XOR = 4'd4,  ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6,  ALU_EQ  = 4'd7,  ALU_NE  = 4'd8;
    localparam logic [3:0] ALU_GE  = 4'd10, ALU_LT  = 4'd11, ALU_MUL = 4'd13;
    localparam logic [3:0] ALU_DIV = 4'd14, ALU_REM = 4'd15;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    // Counter value seen on the last permitted stalled cycle
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] trap_cause_q, trap_cause_d;

    logic [3:0] i_ctrl, r_ctrl, br_ctrl;
    logic       i_ill, r_ill, br_ill;
    logic       timeout;
    state_t     mem_next;

    logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c, pc_src_c;
    logic       reg_write_c, alu_src_a_c, trap_c;
    logic [1:0] wb_sel_c, alu_src_b_c;
    logic [3:0] alu_ctrl_c;

    // Instruction field decode into ALU op codes and legality flags
    always_comb begin
        i_ctrl = ALU_ADD;
        i_ill  = 1'b0;
        case (funct3)
            3'b000:  i_ctrl = ALU_ADD;
            3'b001:  i_ctrl = ALU_SLL;
            3'b010:  i_ctrl = ALU_LT;
            3'b100:  i_ctrl = ALU_XOR;
            3'b101:  i_ctrl = ALU_SRL;
            3'b110:  i_ctrl = ALU_OR;
            3'b111:  i_ctrl = ALU_AND;
            default: i_ill  = 1'b1;
        endcase

        r_ctrl = i_ctrl;
        r_ill  = i_ill;
        if (funct7 == 7'b0000001) begin
            // M extension; illegal as a whole when the multiplier is not built
            r_ctrl = ALU_ADD;
            r_ill  = (ENABLE_M == 0);
            case (funct3)
                3'b000:  r_ctrl = ALU_MUL;
                3'b100:  r_ctrl = ALU_DIV;
                3'b110:  r_ctrl = ALU_REM;
                default: r_ill  = 1'b1;
            endcase
        end else if (funct7 == 7'b0100000) begin
            // Only SUB uses this funct7; there is no arithmetic shift op
            r_ctrl = ALU_SUB;
            r_ill  = (funct3 != 3'b000);
        end else if (funct7 != 7'b0000000) begin
            r_ill  = 1'b1;
        end

        br_ctrl = ALU_EQ;
        br_ill  = 1'b0;
        case (funct3)
            3'b000:  br_ctrl = ALU_EQ;
            3'b001:  br_ctrl = ALU_NE;
            3'b100:  br_ctrl = ALU_LT;
            3'b101:  br_ctrl = ALU_GE;
            default: br_ill  = 1'b1;
        endcase
    end

    // Next-state, stall counter and trap cause selection
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = 8'd0;
        trap_cause_d = trap_cause_q;
        timeout      = (MEM_WAIT_MAX != 0) && (wait_cnt_q == WAIT_LAST);
        mem_next     = S_DECODE;
        if (state_q == S_MEM_RD) mem_next = S_WB_MEM;
        if (state_q == S_MEM_WR) mem_next = S_FETCH;

        case (state_q)
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                // A completion on the final allowed cycle beats the timeout
                if (mem_ready) begin
                    state_d = mem_next;
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    7'b0110011: state_d = r_ill  ? S_TRAP : S_EXEC_R;
                    7'b0010011: state_d = i_ill  ? S_TRAP : S_EXEC_I;
                    7'b0000011,
                    7'b0100011: state_d = S_ADDR;
                    7'b1100011: state_d = br_ill ? S_TRAP : S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    default:    state_d = S_TRAP;
                endcase
                if (state_d == S_TRAP) trap_cause_d = CAUSE_ILLEGAL;
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR:   state_d = (opcode == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
    end

    // State, stall counter and trap cause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= 8'd0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Datapath strobes decoded from the current state
    always_comb begin
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 1'b0;
        reg_write_c = 1'b0;
        wb_sel_c    = 2'd0;
        alu_src_a_c = 1'b0;
        alu_src_b_c = 2'd0;
        alu_ctrl_c  = ALU_ADD;
        trap_c      = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = 2'd1;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
            end
            S_DECODE: alu_src_b_c = 2'd2;
            S_EXEC_R: begin
                alu_src_a_c = 1'b1;
                alu_ctrl_c  = r_ctrl;
            end
            S_EXEC_I: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd2;
                alu_ctrl_c  = i_ctrl;
            end
            S_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'd2;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
            end
            S_WB_ALU: reg_write_c = 1'b1;
            S_WB_MEM: begin
                reg_write_c = 1'b1;
                wb_sel_c    = 2'd1;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_ctrl_c  = br_ctrl;
                pc_write_c  = branch_res;
                pc_src_c    = 1'b1;
            end
            S_JAL: begin
                reg_write_c = 1'b1;
                wb_sel_c    = 2'd2;
                pc_write_c  = 1'b1;
                pc_src_c    = 1'b1;
            end
            S_TRAP:  trap_c = 1'b1;
            default: trap_c = 1'b0;
        endcase
    end

    // Reset forces every output low immediately, even mid-transaction
    assign mem_req    = rst_n & mem_req_c;
    assign mem_we     = rst_n & mem_we_c;
    assign iord       = rst_n & iord_c;
    assign ir_write   = rst_n & ir_write_c;
    assign pc_write   = rst_n & pc_write_c;
    assign pc_src     = rst_n & pc_src_c;
    assign reg_write  = rst_n & reg_write_c;
    assign wb_sel     = rst_n ? wb_sel_c    : 2'd0;
    assign alu_src_a  = rst_n & alu_src_a_c;
    assign alu_src_b  = rst_n ? alu_src_b_c : 2'd0;
    assign alu_ctrl   = rst_n ? alu_ctrl_c  : 4'd0;
    assign trap       = rst_n & trap_c;
    assign trap_cause = rst_n ? trap_cause_q : 2'd0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: one instance with the M extension and a
// short memory timeout, one without the M extension sharing the same inputs.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       branch_res;
    logic       mem_ready;

    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, alu_src_a, trap;
    logic [1:0] wb_sel, alu_src_b, trap_cause;
    logic [3:0] alu_ctrl;

    logic       mem_req_n, mem_we_n, iord_n, ir_write_n, pc_write_n, pc_src_n, reg_write_n;
    logic       alu_src_a_n, trap_n;
    logic [1:0] wb_sel_n, alu_src_b_n, trap_cause_n;
    logic [3:0] alu_ctrl_n;

    int n_checks = 0;
    int n_errors = 0;

    mc_control_fsm #(.ENABLE_M(1), .MEM_WAIT_MAX(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .branch_res(branch_res), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .trap(trap), .trap_cause(trap_cause)
    );

    mc_control_fsm #(.ENABLE_M(0), .MEM_WAIT_MAX(8)) u_dut_nom (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .branch_res(branch_res), .mem_ready(mem_ready), .mem_req(mem_req_n), .mem_we(mem_we_n),
        .iord(iord_n), .ir_write(ir_write_n), .pc_write(pc_write_n), .pc_src(pc_src_n),
        .reg_write(reg_write_n), .wb_sel(wb_sel_n), .alu_src_a(alu_src_a_n),
        .alu_src_b(alu_src_b_n), .alu_ctrl(alu_ctrl_n), .trap(trap_n), .trap_cause(trap_cause_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance one cycle; sample 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    // From FETCH with mem_ready=1: DECODE, EXEC, WB_ALU, back to FETCH
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int exp_ctrl, input int exp_src_b);
        set_ir(op, f3, f7);
        mem_ready = 1'b1;
        #1;
        check_eq({tag, "_fetch_irw"}, ir_write, 1);
        tick();
        check_eq({tag, "_dec_srcb"}, alu_src_b, 2);
        tick();
        check_eq({tag, "_ex_ctrl"}, alu_ctrl, exp_ctrl);
        check_eq({tag, "_ex_srca"}, alu_src_a, 1);
        check_eq({tag, "_ex_srcb"}, alu_src_b, exp_src_b);
        tick();
        check_eq({tag, "_wb_regw"}, reg_write, 1);
        check_eq({tag, "_wb_sel"}, wb_sel, 0);
        tick();
        check_eq({tag, "_back_fetch"}, mem_req, 1);
    endtask

    // From FETCH with mem_ready=1: DECODE, BRANCH (both branch_res values), FETCH
    task automatic run_branch(input string tag, input logic [2:0] f3, input int exp_ctrl);
        set_ir(7'b1100011, f3, 7'b0000000);
        mem_ready = 1'b1;
        tick();
        tick();
        branch_res = 1'b1;
        #1;
        check_eq({tag, "_ctrl"}, alu_ctrl, exp_ctrl);
        check_eq({tag, "_pcw_taken"}, pc_write, 1);
        check_eq({tag, "_pcsrc"}, pc_src, 1);
        branch_res = 1'b0;
        #1;
        check_eq({tag, "_pcw_not_taken"}, pc_write, 0);
        tick();
        check_eq({tag, "_back_fetch"}, mem_req, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        branch_res = 1'b0;
        mem_ready = 1'b0;
        set_ir(7'b0110011, 3'b000, 7'b0000000);

        repeat (2) tick();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_alu_src_b", alu_src_b, 0);
        check_eq("rst_trap", trap, 0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_fetch_req", mem_req, 1);
        check_eq("post_rst_iord", iord, 0);
        check_eq("post_rst_cause", trap_cause, 0);
        check_eq("post_rst_irw_stall", ir_write, 0);

        mem_ready = 1'b1;
        #1;
        check_eq("fetch_pcw", pc_write, 1);
        check_eq("fetch_srcb", alu_src_b, 1);
        check_eq("fetch_ctrl", alu_ctrl, 0);

        run_alu("add", 7'b0110011, 3'b000, 7'b0000000, 0, 0);
        run_alu("sub", 7'b0110011, 3'b000, 7'b0100000, 1, 0);
        run_alu("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 0, 2);
        run_alu("xori", 7'b0010011, 3'b100, 7'b0000000, 4, 2);
        run_alu("slt", 7'b0110011, 3'b010, 7'b0000000, 11, 0);
        run_alu("rem", 7'b0110011, 3'b110, 7'b0000001, 15, 0);
        check_eq("nom_rem_trap", trap_n, 1);
        check_eq("nom_rem_cause", trap_cause_n, 1);
        check_eq("nom_rem_mem_req", mem_req_n, 0);
        run_alu("mul", 7'b0110011, 3'b000, 7'b0000001, 13, 0);
        check_eq("m_no_trap", trap, 0);

        run_branch("beq", 3'b000, 7);
        run_branch("bge", 3'b101, 10);

        // JAL
        set_ir(7'b1101111, 3'b000, 7'b0000000);
        tick();
        tick();
        check_eq("jal_regw", reg_write, 1);
        check_eq("jal_wbsel", wb_sel, 2);
        check_eq("jal_pcw", pc_write, 1);
        check_eq("jal_pcsrc", pc_src, 1);
        tick();
        check_eq("jal_back_fetch", mem_req, 1);

        // Load with three stalled cycles in MEM_RD
        set_ir(7'b0000011, 3'b010, 7'b0000000);
        tick();
        tick();
        check_eq("lw_addr_srca", alu_src_a, 1);
        check_eq("lw_addr_srcb", alu_src_b, 2);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("lw_stall_req", mem_req, 1);
            check_eq("lw_stall_iord", iord, 1);
            check_eq("lw_stall_we", mem_we, 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("lw_done_req", mem_req, 1);
        check_eq("lw_done_iord", iord, 1);
        tick();
        check_eq("lw_wb_regw", reg_write, 1);
        check_eq("lw_wb_sel", wb_sel, 1);
        tick();
        check_eq("lw_back_fetch", mem_req, 1);
        check_eq("lw_back_iord", iord, 0);

        // Seven stalls in FETCH, then mem_ready on the eighth (last) cycle wins
        set_ir(7'b0110011, 3'b000, 7'b0000000);
        mem_ready = 1'b0;
        repeat (7) tick();
        check_eq("edge_still_fetch", mem_req, 1);
        mem_ready = 1'b1;
        #1;
        check_eq("edge_irw", ir_write, 1);
        tick();
        check_eq("edge_decode", alu_src_b, 2);
        check_eq("edge_no_trap", trap, 0);
        tick();
        tick();
        tick();
        check_eq("edge_back_fetch", mem_req, 1);

        // Store stalling in MEM_WR, reset asserted mid-cycle
        set_ir(7'b0100011, 3'b010, 7'b0000000);
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check_eq("sw_req", mem_req, 1);
        check_eq("sw_we", mem_we, 1);
        check_eq("sw_iord", iord, 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("sw_rst_req", mem_req, 0);
        check_eq("sw_rst_we", mem_we, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("sw_rel_fetch", mem_req, 1);
        check_eq("sw_rel_we", mem_we, 0);
        check_eq("sw_rel_trap", trap, 0);
        check_eq("nom_rel_trap", trap_n, 0);

        // mem_ready stuck low in FETCH: eight stalled cycles then timeout trap
        repeat (7) tick();
        check_eq("to_8th_stall_req", mem_req, 1);
        check_eq("to_8th_stall_trap", trap, 0);
        tick();
        check_eq("to_trap", trap, 1);
        check_eq("to_cause", trap_cause, 2);
        check_eq("to_mem_req", mem_req, 0);
        mem_ready = 1'b1;
        repeat (3) tick();
        check_eq("to_sticky_trap", trap, 1);
        check_eq("to_sticky_cause", trap_cause, 2);
        check_eq("to_sticky_req", mem_req, 0);
        check_eq("to_sticky_irw", ir_write, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
